// File: rtl/axil_mem_slave_if.sv
// axil_mem_slave_if: AXI4-Lite bus bundle for the memory slave
// Carries the AW, W, B, AR and R channels. The slave modport is used by axil_mem_slave;
// the master modport is for whatever drives the bus.
interface axil_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
               s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
               s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
               s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
               s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );
endinterface

// File: rtl/axil_mem_slave.sv
// axil_mem_slave: AXI4-Lite RAM slave with independent write and read state machines
// Ports:
//   s_axi_aclk   - clock, all logic on the rising edge
//   s_axi_areset - synchronous active-high reset; idles both FSMs, zeroes outputs and memory
//   s            - axil_mem_slave_if.slave (AW/W/B/AR/R channels)
// Build option: AXIL_MEM_WSTRB_EN enables per-byte write strobes; when undefined the
// strobe port is ignored and every committed write updates the full word.
module axil_mem_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 128,
    parameter int READ_LATENCY = 2
) (
    input logic             s_axi_aclk,
    input logic             s_axi_areset,
    axil_mem_slave_if.slave s
);
    localparam int SW   = DATA_WIDTH / 8;
    localparam int OFFS = $clog2(SW);
    localparam int IW   = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {W_IDLE, W_NEED_D, W_NEED_A, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    w_state_t              ws, ws_nxt;
    r_state_t              rs, rs_nxt;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q, aw_idx, ar_idx;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [2:0]            rcnt;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_ok, ar_ok, r_last;
`ifdef AXIL_MEM_WSTRB_EN
    logic [SW-1:0]         wstrb_q;
`endif

    // Byte offset bits are dropped; anything at or beyond DEPTH is a decode error.
    assign aw_idx = awaddr_q >> OFFS;
    assign ar_idx = araddr_q >> OFFS;
    assign aw_ok  = aw_idx < ADDR_WIDTH'(DEPTH);
    assign ar_ok  = ar_idx < ADDR_WIDTH'(DEPTH);
    assign r_last = rcnt == 3'(READ_LATENCY - 1);

    // Outputs are forced low while reset is held, not just after the reset edge.
    assign s.s_axi_awready = !s_axi_areset && (ws == W_IDLE || ws == W_NEED_A);
    assign s.s_axi_wready  = !s_axi_areset && (ws == W_IDLE || ws == W_NEED_D);
    assign s.s_axi_bvalid  = !s_axi_areset && ws == W_RESP;
    assign s.s_axi_bresp   = s_axi_areset ? 2'b00 : bresp_q;
    assign s.s_axi_arready = !s_axi_areset && rs == R_IDLE;
    assign s.s_axi_rvalid  = !s_axi_areset && rs == R_RESP;
    assign s.s_axi_rresp   = s_axi_areset ? 2'b00 : rresp_q;
    assign s.s_axi_rdata   = s_axi_areset ? '0 : rdata_q;

    assign aw_hs = s.s_axi_awvalid && s.s_axi_awready;
    assign w_hs  = s.s_axi_wvalid && s.s_axi_wready;
    assign b_hs  = s.s_axi_bvalid && s.s_axi_bready;
    assign ar_hs = s.s_axi_arvalid && s.s_axi_arready;
    assign r_hs  = s.s_axi_rvalid && s.s_axi_rready;

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) ws <= W_IDLE;
        else ws <= ws_nxt;
    end

    always_comb begin
        ws_nxt = ws;
        unique case (ws)
            W_IDLE:   ws_nxt = aw_hs && w_hs ? W_COMMIT : aw_hs ? W_NEED_D : w_hs ? W_NEED_A : W_IDLE;
            W_NEED_D: ws_nxt = w_hs ? W_COMMIT : W_NEED_D;
            W_NEED_A: ws_nxt = aw_hs ? W_COMMIT : W_NEED_A;
            W_COMMIT: ws_nxt = W_RESP;
            W_RESP:   ws_nxt = b_hs ? W_IDLE : W_RESP;
            default:  ws_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            bresp_q  <= 2'b00;
`ifdef AXIL_MEM_WSTRB_EN
            wstrb_q  <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (aw_hs) awaddr_q <= s.s_axi_awaddr;
            if (w_hs) begin
                wdata_q <= s.s_axi_wdata;
`ifdef AXIL_MEM_WSTRB_EN
                wstrb_q <= s.s_axi_wstrb;
`endif
            end
            if (ws == W_COMMIT) begin
                bresp_q <= aw_ok ? 2'b00 : 2'b11;
                if (aw_ok) begin
`ifdef AXIL_MEM_WSTRB_EN
                    for (int b = 0; b < SW; b++)
                        if (wstrb_q[b]) mem[aw_idx[IW-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
`else
                    mem[aw_idx[IW-1:0]] <= wdata_q;
`endif
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) rs <= R_IDLE;
        else rs <= rs_nxt;
    end

    always_comb begin
        rs_nxt = rs;
        unique case (rs)
            R_IDLE:  rs_nxt = ar_hs ? R_WAIT : R_IDLE;
            R_WAIT:  rs_nxt = r_last ? R_RESP : R_WAIT;
            R_RESP:  rs_nxt = r_hs ? R_IDLE : R_RESP;
            default: rs_nxt = R_IDLE;
        endcase
    end

    // The sample reads mem through a non-blocking update, so a commit to the same
    // word on the same edge is not visible: the read returns the pre-write data.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            araddr_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            rcnt     <= 3'd0;
        end else begin
            if (ar_hs) araddr_q <= s.s_axi_araddr;
            rcnt <= rs == R_WAIT ? rcnt + 3'd1 : 3'd0;
            if (rs == R_WAIT && r_last) begin
                rdata_q <= ar_ok ? mem[ar_idx[IW-1:0]] : '0;
                rresp_q <= ar_ok ? 2'b00 : 2'b11;
            end
            if (r_hs) begin
                rdata_q <= '0;
                rresp_q <= 2'b00;
            end
        end
    end
endmodule
